// File: rtl/divider_rr_scheduler.sv
// Purpose: shares one pipelined unsigned divider between NREQ requesters using
//          round-robin arbitration. Requester ID and a divide-by-zero flag
//          travel in a tag pipeline aligned to the divider latency.
// Ports:   clk/reset (async, active-high); hold freezes arbitration, divider
//          and tags; req_* is the valid/ready request side with flattened
//          operands; div_* drives and receives the external divider; rsp_* is
//          a one-cycle response strobe with registered data; busy flags work
//          in flight.
module divider_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTHN  = 16,
  parameter int WIDTHD  = 8,
  parameter int LATENCY = 4,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTHN-1:0]   req_numer,
  input  logic [NREQ*WIDTHD-1:0]   req_denom,
  output logic [WIDTHN-1:0]        div_numer,
  output logic [WIDTHD-1:0]        div_denom,
  output logic                     div_clken,
  input  logic [WIDTHN-1:0]        div_quotient,
  input  logic [WIDTHD-1:0]        div_remain,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTHN-1:0]        rsp_quotient,
  output logic [WIDTHD-1:0]        rsp_remain,
  output logic                     rsp_dbz,
  output logic                     busy
);

  // Operand arrays unpacked from the flattened buses.
  logic [WIDTHN-1:0] numer_arr [NREQ];
  logic [WIDTHD-1:0] denom_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign numer_arr[g] = req_numer[g*WIDTHN +: WIDTHN];
    assign denom_arr[g] = req_denom[g*WIDTHD +: WIDTHD];
  end

  // Round-robin pointer: index of the most recent grant.
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           grant_found;
  logic           fire;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int j = 1; j <= NREQ; j++) begin
      cand = IDW'((int'(ptr) + j) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset gating keeps ready low while reset is asserted.
  assign fire = grant_found & ~hold & ~reset;

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[grant_idx] = 1'b1;
  end

  assign div_clken = ~hold;

  // Tag pipeline: stage 0 lines up with div_numer, stage LATENCY with the
  // divider result.
  logic [LATENCY:0] tag_vld;
  logic [LATENCY:0] tag_dbz;
  logic [IDW-1:0]   tag_id [LATENCY+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= IDW'(NREQ - 1);
      div_numer    <= '0;
      div_denom    <= {{(WIDTHD-1){1'b0}}, 1'b1};
      tag_vld      <= '0;
      tag_dbz      <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_id[i] <= '0;
      rsp_valid    <= '0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
      rsp_remain   <= '0;
      rsp_dbz      <= 1'b0;
    end else if (hold) begin
      // Everything freezes; only the strobe is forced low.
      rsp_valid <= '0;
    end else begin
      // Issue side
      tag_vld <= {tag_vld[LATENCY-1:0], fire};
      tag_dbz <= {tag_dbz[LATENCY-1:0], (denom_arr[grant_idx] == '0)};
      tag_id[0] <= grant_idx;
      for (int i = 1; i <= LATENCY; i++) tag_id[i] <= tag_id[i-1];
      if (fire) begin
        div_numer <= numer_arr[grant_idx];
        div_denom <= denom_arr[grant_idx];
        ptr       <= grant_idx;
      end

      // Retire side: divider output is meaningless for a zero denominator,
      // so substitute saturated quotient and zero remainder.
      if (tag_vld[LATENCY]) begin
        rsp_valid    <= {{(NREQ-1){1'b0}}, 1'b1} << tag_id[LATENCY];
        rsp_id       <= tag_id[LATENCY];
        rsp_dbz      <= tag_dbz[LATENCY];
        rsp_quotient <= tag_dbz[LATENCY] ? '1 : div_quotient;
        rsp_remain   <= tag_dbz[LATENCY] ? '0 : div_remain;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign busy = |tag_vld;

endmodule

// File: doc/divider_rr_scheduler.md
Name: divider_rr_scheduler

Overview:
- Shares one pipelined `divider_unsigned` instance (fixed LATENCY, one issue per enabled cycle) between NREQ requesters.
- Round-robin arbitration with valid/ready request handshakes.
- Carries requester ID and a divide-by-zero flag through a tag pipeline aligned to the divider latency.
- Returns each result to its requester as a one-cycle response strobe.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTHN, 16, numerator/quotient width
- WIDTHD, 8, denominator/remainder width
- LATENCY, 4, divider latency in enabled clocks; must match the divider configuration
- IDW, 2, requester ID width, equals clog2(NREQ)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hold  in  1  freeze: no grants; divider and tag pipeline stalled
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_numer  in  NREQ*WIDTHN  flattened numerators; requester i occupies bits [i*WIDTHN +: WIDTHN]
- req_denom  in  NREQ*WIDTHD  flattened denominators, same packing
- div_numer  out  WIDTHN  registered operand to divider
- div_denom  out  WIDTHD  registered operand to divider
- div_clken  out  1  divider clock enable, equals ~hold
- div_quotient  in  WIDTHN  divider quotient
- div_remain  in  WIDTHD  divider remainder
- rsp_valid  out  NREQ  one-hot response strobe, one cycle
- rsp_id  out  IDW  ID of the responding requester
- rsp_quotient  out  WIDTHN  registered quotient
- rsp_remain  out  WIDTHD  registered remainder
- rsp_dbz  out  1  response was a divide by zero
- busy  out  1  any tag stage valid

Behaviour:
- Reset values (asynchronous):
  - req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remain, rsp_dbz, busy = 0.
  - div_numer = 0, div_denom = 1.
  - All tag stages invalid; RR pointer = NREQ-1, so requester 0 wins first.
- Arbitration (combinational on req_valid, hold, pointer):
  - If hold=0, grant the first asserted req_valid searching from pointer+1 upward, wrapping modulo NREQ.
  - req_ready has that single bit set; otherwise req_ready = 0.
  - A handshake is req_valid[i] & req_ready[i].
  - Requesters may drop req_valid without a handshake. Operands need only be stable in the handshake cycle.
- Issue (edge of the handshake cycle):
  - div_numer/div_denom load the granted operands.
  - Tag stage 0 loads {valid=1, id, dbz = (denom==0)}.
  - Pointer loads the granted index.
  - With no handshake and hold=0, tag stage 0 loads valid=0; operands keep their last values.
- Tag pipeline:
  - Stages 0..LATENCY; each stage shifts to the next on every edge with hold=0; all stages freeze while hold=1.
  - Stage 0 aligns with div_numer; stage LATENCY aligns with div_quotient.
- Response (registered):
  - On an edge with hold=0 and tag[LATENCY].valid: rsp_valid = onehot(id), rsp_id = id.
  - rsp_quotient = dbz ? all-ones : div_quotient; rsp_remain = dbz ? 0 : div_remain; rsp_dbz = dbz.
  - Otherwise rsp_valid = 0. Data outputs hold their last values.
  - While hold=1, rsp_valid = 0.
- Timing and throughput:
  - Latency: handshake at edge k gives rsp_valid high for exactly one cycle after edge k+LATENCY+1, absent hold.
  - Each hold cycle adds one cycle of latency.
  - Throughput: one issue per non-hold cycle. Responses are in issue order. Responses have no backpressure; requesters must accept them.
- Simultaneous events: a new issue and a retiring response on the same edge are both handled, with no bubble.
- busy = OR of all tag-stage valid bits.
- Reset mid-operation: all in-flight tags are discarded; no response is emitted for them after reset releases.

Test Plan:
- NREQ=4, WIDTHN=16, WIDTHD=8, LATENCY=4, hold=0. Requester 0 issues 8/3 once -> req_ready[0] in the same cycle; rsp_valid=4'b0001 exactly 5 cycles later; rsp_quotient=2, rsp_remain=2, rsp_dbz=0; busy low afterwards.
- All four requesters hold req_valid for 8 cycles with operand i = (100+i)/(i+3) -> grant order 0,1,2,3,0,1,2,3; responses in the same order back-to-back; quotients 33,25,20,17; remainders 1,1,2,1.
- Requesters 1 and 3 only, continuous -> grants alternate 1,3,1,3; requester 0 and 2 ready bits never set.
- Requester 2 issues 500/0 -> rsp_valid=4'b0100, rsp_dbz=1, rsp_quotient=16'hFFFF, rsp_remain=0.
- Issue 3 back-to-back requests, then assert hold for 3 cycles during flight -> div_clken low for 3 cycles; no req_ready or rsp_valid during hold; all 3 responses arrive 3 cycles late, none lost or duplicated.
- Issue 2 requests, then pulse reset 2 cycles later -> all outputs at reset values; no responses after release; next request grants requester 0 first.
